multi_edge_req: RTL and testbench
=================================

// Module: multi_edge_req
// PURPOSE
//  N-channel edge-event collector with synchroniser, per-channel glitch filter, per-channel edge
//  mode, sticky pending flags and one shared req/ack request port with fixed priority. Generalises
//  the single-channel falling-edge req pulse into a multi-source request front end for downstream
//  control logic (interrupt-style sources, async buttons, status lines).
// PARAMETERS
//  N_CH        4  number of input channels (1..32)
//  SYNC_STAGES 2  flops in each input synchroniser chain (>=2)
//  FILT_W      4  width of filt_len and the per-channel filter counters
// PORTS
//  clk      in   1             clock, all logic on rising edge
//  rst_n    in   1             reset, asynchronous, active-low
//  sig_in   in   N_CH          asynchronous channel inputs, idle level high
//  mode     in   2*N_CH        per-channel edge select, ch i = mode[2i+1:2i]: 00 off, 01 fall, 10 rise, 11 both
//  filt_len in   FILT_W        consecutive stable cycles required before a level change is accepted
//  req      out  1             request valid; held until ack
//  req_ch   out  clog2(N_CH)   channel index of the current request (1 bit min when N_CH=1)
//  ack      in   1             consumer accepts the request while req=1
//  pend     out  N_CH          pending-event flags
//  overrun  out  N_CH          sticky: an event arrived while the same channel was already pending
//  clr_ovr  in   N_CH          per-bit clear of overrun, one cycle
// BEHAVIOUR
//  Reset: sync chains, filtered levels = 1; counters = 0; pend, overrun, req, req_ch = 0.
//  Sync: sig_in[i] passes SYNC_STAGES flops -> s[i]; no other logic reads sig_in directly.
//  Filter, per channel: f[i] = accepted level; cnt[i] counts cycles with s[i] != f[i].
//   - s == f: cnt <= 0.
//   - s != f and cnt == filt_len: f <= s, cnt <= 0 (filt_len = 0 -> f follows s one cycle later).
//   - otherwise cnt <= cnt + 1; a glitch shorter than filt_len+1 cycles never changes f.
//   - filt_len changed mid-count: compare uses the new value at once, no clear.
//  Edge: fall = f_d & ~f, rise = ~f_d & f (f_d = f one cycle earlier); ev[i] = edge matched by mode[i].
//   - mode read every cycle; mode 00 blocks new events, does not clear existing pend.
//  Latency: clean sig_in step -> pend[i] high on clock edge SYNC_STAGES + filt_len + 2
//   (+/-1 for async sampling); pend -> req one further cycle.
//  pend/overrun, per channel, evaluated each cycle:
//   - ev & ~pend -> pend <= 1.
//   - ack & req & req_ch == i clears pend[i]; same-cycle ev[i] keeps pend[i] = 1 (new event, no overrun).
//   - ev & pend with no same-cycle clear -> overrun[i] <= 1, pend stays 1.
//   - clr_ovr[i] clears overrun[i]; a same-cycle overrun set wins.
//  Request port (registered, valid/ready style):
//   - req = 0 and any pend bit set: next cycle req = 1, req_ch = lowest set pend index.
//   - req = 1, ack = 0: req and req_ch held stable, even if a lower-index channel becomes pending.
//   - req = 1, ack = 1: next cycle req_ch = lowest index in (pend after this cycle's update),
//     req = 1 if any remain, else 0. Back-to-back grants need no idle cycle.
//   - ack while req = 0: ignored.
//  Async reset mid-operation: all state to reset values immediately; pending events are lost.
//   A low input held across reset release yields one falling event after the latency above.
// TESTING
//  1 N_CH=4, filt_len=0, mode=01 all: ch2 1->0 -> pend=0100 after 4 clk, req=1, req_ch=2 next clk;
//    ack 1 clk -> pend=0000, req=0.
//  2 filt_len=3, ch0 low pulse 3 clk -> no pend; low pulse 4+ clk -> pend[0]=1 exactly once.
//  3 mode ch1=11: ch1 1->0, held 10 clk, 0->1 -> two events; second before ack -> overrun[1]=1;
//    clr_ovr[1] -> overrun[1]=0.
//  4 ch3 pending and granted (req_ch=3, ack low), then ch0 event -> req_ch stays 3;
//    ack -> next clk req_ch=0 with req held high.
//  5 ack on ch1 in same cycle as new ch1 event -> pend[1] stays 1, overrun[1]=0, ch1 granted again.
//  6 rst_n low while req=1 and pend=1010 -> req, pend, overrun = 0 immediately; no spurious
//    event after release with sig_in high.

Source files
------------

// File: rtl/multi_edge_req.sv
// multi_edge_req
// Multi-channel edge-event collector. Each asynchronous input is synchronised
// and then glitch-filtered. A per-channel mode selects which edges of the
// filtered level raise an event. Events set sticky pending flags, and a
// repeated event on a channel that is already pending sets its overrun flag.
// Pending channels are served one at a time, lowest index first, through a
// single registered req/ack port.
module multi_edge_req #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  localparam int RCH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     i_sig_in,
  input  logic [2*N_CH-1:0]   i_mode,
  input  logic [FILT_W-1:0]   i_filt_len,
  output logic                o_req,
  output logic [RCH_W-1:0]    o_req_ch,
  input  logic                i_ack,
  output logic [N_CH-1:0]     o_pend,
  output logic [N_CH-1:0]     o_overrun,
  input  logic [N_CH-1:0]     i_clr_ovr
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Returns the lowest set index. Returns 0 when nothing is set; callers only
  // use the result when at least one bit is set.
  function automatic logic [RCH_W-1:0] f_lowest(input logic [N_CH-1:0] v);
    logic [RCH_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = RCH_W'(i);
    end
    return idx;
  endfunction

  logic [N_CH-1:0]   r_sync [SYNC_STAGES];
  logic [N_CH-1:0]   w_s;
  logic [N_CH-1:0]   r_filt;
  logic [N_CH-1:0]   r_filt_d;
  logic [FILT_W-1:0] r_cnt [N_CH];
  logic [N_CH-1:0]   w_fall;
  logic [N_CH-1:0]   w_rise;
  logic [N_CH-1:0]   w_ev;
  logic [N_CH-1:0]   w_clr;
  logic [N_CH-1:0]   r_pend;
  logic [N_CH-1:0]   w_pend_next;
  logic [N_CH-1:0]   r_ovr;
  logic [N_CH-1:0]   w_ovr_next;
  state_t            r_state;
  state_t            w_state_next;
  logic [RCH_W-1:0]  r_req_ch;
  logic [RCH_W-1:0]  w_req_ch_next;

  // Synchroniser chains. They reset to the idle-high level so that reset
  // release with inputs high produces no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '1;
    end else begin
      r_sync[0] <= i_sig_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Glitch filter: the accepted level follows the synchronised level only after
  // the two have differed for filt_len+1 consecutive cycles. The >= compare
  // means that lowering filt_len mid-count takes effect at once and cannot
  // strand the counter above the new threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= '1;
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_s[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= i_filt_len) begin
          r_filt[i] <= w_s[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + FILT_W'(1);
        end
      end
    end
  end

  // One-cycle delayed copy of the filtered level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_filt_d <= '1;
    else        r_filt_d <= r_filt;
  end

  assign w_fall = r_filt_d & ~r_filt;
  assign w_rise = ~r_filt_d & r_filt;

  // Per-channel event select. mode bit 0 enables falling edges and bit 1
  // enables rising edges, so 11 gives both and 00 gives none.
  always_comb begin
    w_ev = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_ev[i] = (i_mode[2*i] & w_fall[i]) | (i_mode[2*i+1] & w_rise[i]);
    end
  end

  // Pending and overrun next state. An acknowledge clears the granted channel,
  // but an event in the same cycle re-arms it as a fresh event without overrun.
  // An overrun set wins over a same-cycle clr_ovr.
  always_comb begin
    w_clr       = '0;
    w_pend_next = r_pend;
    w_ovr_next  = r_ovr;
    for (int i = 0; i < N_CH; i++) begin
      w_clr[i] = i_ack & (r_state == ST_GRANT) & (r_req_ch == RCH_W'(i));
      if (w_ev[i])       w_pend_next[i] = 1'b1;
      else if (w_clr[i]) w_pend_next[i] = 1'b0;
      if (w_ev[i] & r_pend[i] & ~w_clr[i]) w_ovr_next[i] = 1'b1;
      else if (i_clr_ovr[i])                w_ovr_next[i] = 1'b0;
    end
  end

  // Pending and overrun flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_ovr  <= '0;
    end else begin
      r_pend <= w_pend_next;
      r_ovr  <= w_ovr_next;
    end
  end

  // Request state register and latched channel index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_req_ch <= '0;
    end else begin
      r_state  <= w_state_next;
      r_req_ch <= w_req_ch_next;
    end
  end

  // Request arbitration. While granted without ack, the channel index is
  // frozen. On ack, the next grant comes from the pending set after this
  // cycle's update, which allows back-to-back grants with no idle cycle.
  always_comb begin
    w_state_next  = r_state;
    w_req_ch_next = r_req_ch;
    case (r_state)
      ST_IDLE: begin
        if (|r_pend) begin
          w_state_next  = ST_GRANT;
          w_req_ch_next = f_lowest(r_pend);
        end
      end
      ST_GRANT: begin
        if (i_ack) begin
          if (|w_pend_next) begin
            w_state_next  = ST_GRANT;
            w_req_ch_next = f_lowest(w_pend_next);
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign o_req     = (r_state == ST_GRANT);
  assign o_req_ch  = r_req_ch;
  assign o_pend    = r_pend;
  assign o_overrun = r_ovr;

endmodule

// File: tb/tb_multi_edge_req.sv
// Directed bench for multi_edge_req with N_CH=4, SYNC_STAGES=2, FILT_W=4.
module tb_multi_edge_req;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig_in;
  logic [7:0] mode;
  logic [3:0] filt_len;
  logic       req;
  logic [1:0] req_ch;
  logic       ack;
  logic [3:0] pend;
  logic [3:0] overrun;
  logic [3:0] clr_ovr;

  int n_chk = 0;
  int n_err = 0;

  multi_edge_req #(.N_CH(4), .SYNC_STAGES(2), .FILT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sig_in   (sig_in),
    .i_mode     (mode),
    .i_filt_len (filt_len),
    .o_req      (req),
    .o_req_ch   (req_ch),
    .i_ack      (ack),
    .o_pend     (pend),
    .o_overrun  (overrun),
    .i_clr_ovr  (clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    sig_in   = 4'b1111;
    mode     = 8'h55;
    filt_len = 4'd0;
    ack      = 1'b0;
    clr_ovr  = 4'b0000;
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_req_ch", 32'(req_ch), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(6);
    chk("idle_pend", 32'(pend), 32'd0);
    chk("idle_req", 32'(req), 32'd0);

    // 1: ch2 falls, filt_len 0 -> pend at edge 4, req at edge 5
    sig_in = 4'b1011;
    tick(3);
    chk("t1_pend_e3", 32'(pend), 32'd0);
    tick(1);
    chk("t1_pend_e4", 32'(pend), 32'h4);
    chk("t1_req_e4", 32'(req), 32'd0);
    tick(1);
    chk("t1_req_e5", 32'(req), 32'd1);
    chk("t1_req_ch", 32'(req_ch), 32'd2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t1_pend_ack", 32'(pend), 32'd0);
    chk("t1_req_ack", 32'(req), 32'd0);
    sig_in = 4'b1111;
    tick(6);
    chk("t1_rise_ignored", 32'(pend), 32'd0);

    // 2: filt_len 3, 3-cycle glitch rejected, 4-cycle pulse accepted once
    filt_len = 4'd3;
    sig_in = 4'b1110;
    tick(3);
    sig_in = 4'b1111;
    tick(12);
    chk("t2_glitch3", 32'(pend), 32'd0);
    sig_in = 4'b1110;
    tick(4);
    sig_in = 4'b1111;
    tick(2);
    chk("t2_pend_e6", 32'(pend), 32'd0);
    tick(1);
    chk("t2_pend_e7", 32'(pend), 32'h1);
    tick(12);
    chk("t2_pend_once", 32'(pend), 32'h1);
    chk("t2_no_ovr", 32'(overrun), 32'd0);
    chk("t2_req_ch", 32'(req_ch), 32'd0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t2_cleared", 32'(pend), 32'd0);
    filt_len = 4'd0;

    // 3: ch1 both edges, second event before ack -> overrun, then clr_ovr
    mode = 8'h5D;
    sig_in = 4'b1101;
    tick(10);
    chk("t3_pend", 32'(pend), 32'h2);
    chk("t3_req_ch", 32'(req_ch), 32'd1);
    chk("t3_ovr_pre", 32'(overrun), 32'd0);
    sig_in = 4'b1111;
    tick(5);
    chk("t3_ovr_set", 32'(overrun), 32'h2);
    chk("t3_pend_kept", 32'(pend), 32'h2);
    clr_ovr = 4'b0010;
    tick(1);
    clr_ovr = 4'b0000;
    chk("t3_ovr_clr", 32'(overrun), 32'd0);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t3_drained", 32'(pend), 32'd0);

    // 4: grant to ch3 frozen while ch0 arrives; ack moves straight to ch0
    mode = 8'h55;
    sig_in = 4'b0111;
    tick(5);
    chk("t4_req", 32'(req), 32'd1);
    chk("t4_req_ch3", 32'(req_ch), 32'd3);
    sig_in = 4'b0110;
    tick(5);
    chk("t4_pend", 32'(pend), 32'h9);
    chk("t4_hold_ch3", 32'(req_ch), 32'd3);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t4_b2b_req", 32'(req), 32'd1);
    chk("t4_b2b_ch0", 32'(req_ch), 32'd0);
    chk("t4_pend_after", 32'(pend), 32'h1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t4_idle", 32'(req), 32'd0);
    sig_in = 4'b1111;
    tick(6);

    // 5: ack on ch1 in the same cycle as a new ch1 event
    mode = 8'h5D;
    sig_in = 4'b1101;
    tick(6);
    chk("t5_req_ch1", 32'(req_ch), 32'd1);
    sig_in = 4'b1111;
    tick(3);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t5_pend_kept", 32'(pend), 32'h2);
    chk("t5_no_ovr", 32'(overrun), 32'd0);
    chk("t5_regrant", 32'(req), 32'd1);
    chk("t5_regrant_ch", 32'(req_ch), 32'd1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("t5_drained", 32'(pend), 32'd0);

    // 6: async reset while requesting with pend=1010
    mode = 8'h55;
    sig_in = 4'b0101;
    tick(6);
    chk("t6_pend", 32'(pend), 32'hA);
    chk("t6_req", 32'(req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(req), 32'd0);
    chk("t6_rst_pend", 32'(pend), 32'd0);
    chk("t6_rst_ovr", 32'(overrun), 32'd0);
    sig_in = 4'b1111;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("t6_no_spurious", 32'(pend), 32'd0);
    chk("t6_req_idle", 32'(req), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
